// File: rtl/alu_writeback_if.sv
// Handshake and register-file write bundle between the ALU issue side and the writeback stage.
interface alu_writeback_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_AW = 3
);
  localparam int unsigned FLAG_W = 6;

  logic                  in_valid;
  logic                  in_ready;
  logic [2*DATA_W-1:0]   in_result;
  logic                  in_wide;
  logic                  in_wen;
  logic [REG_AW-1:0]     in_rd;
  logic [FLAG_W-1:0]     in_flags;
  logic                  in_flag_we;
  logic                  rf_we;
  logic [REG_AW-1:0]     rf_waddr;
  logic [DATA_W-1:0]     rf_wdata;
  logic [FLAG_W-1:0]     status;
  logic                  retire;

  // Upstream/observer side.
  modport master (
    output in_valid, in_result, in_wide, in_wen, in_rd, in_flags, in_flag_we,
    input  in_ready, rf_we, rf_waddr, rf_wdata, status, retire
  );

  // Writeback stage side.
  modport slave (
    input  in_valid, in_result, in_wide, in_wen, in_rd, in_flags, in_flag_we,
    output in_ready, rf_we, rf_waddr, rf_wdata, status, retire
  );
endinterface

// File: rtl/alu_writeback.sv
// ALU writeback stage: one register-file write per narrow result, two for a wide product,
// plus the architectural status register.
module alu_writeback #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  alu_writeback_if.slave    bus
);
  localparam int unsigned FLAG_W = 6;
  localparam int unsigned RES_W  = 2 * DATA_W;

  typedef enum logic [1:0] {IDLE, WR_LO, WR_HI} state_t;

  state_t              state;
  logic [RES_W-1:0]    result_q;
  logic                wide_q;
  logic                wen_q;
  logic [REG_AW-1:0]   rd_q;
  logic [FLAG_W-1:0]   status_q;
  logic                ready;
  logic                fire;

  // Ready depends only on state; it drops only while a wide low half is being written.
  assign ready = !rst && !((state == WR_LO) && wide_q);
  assign fire  = bus.in_valid && ready;

  assign bus.in_ready = ready;
  assign bus.status   = status_q;

  // State, holding register and status register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      result_q <= '0;
      wide_q   <= 1'b0;
      wen_q    <= 1'b0;
      rd_q     <= '0;
      status_q <= '0;
    end else begin
      if (fire) begin
        result_q <= bus.in_result;
        wide_q   <= bus.in_wide && bus.in_wen;
        wen_q    <= bus.in_wen;
        rd_q     <= bus.in_rd;
        if (bus.in_flag_we) begin
          status_q <= bus.in_flags;
        end
      end
      case (state)
        IDLE:    state <= fire ? WR_LO : IDLE;
        WR_LO:   state <= wide_q ? WR_HI : (fire ? WR_LO : IDLE);
        WR_HI:   state <= fire ? WR_LO : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Write-port decode from state and holding register; reset suppresses any pending write.
  always_comb begin
    bus.rf_we    = 1'b0;
    bus.retire   = 1'b0;
    bus.rf_waddr = rd_q;
    bus.rf_wdata = result_q[DATA_W-1:0];
    if (rst) begin
      bus.rf_waddr = '0;
      bus.rf_wdata = '0;
    end else begin
      case (state)
        WR_LO: begin
          bus.rf_we  = wen_q;
          bus.retire = !wide_q;
        end
        WR_HI: begin
          bus.rf_we    = 1'b1;
          bus.rf_waddr = rd_q + REG_AW'(1);
          bus.rf_wdata = result_q[RES_W-1:DATA_W];
          bus.retire   = 1'b1;
        end
        default: begin
          bus.rf_we  = 1'b0;
          bus.retire = 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_writeback.sv
// Scoreboard bench for alu_writeback: driver pushes expected write events, monitor checks them.
module tb_alu_writeback;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned REG_AW = 3;

  typedef struct {
    int          due;
    logic        we;
    logic [2:0]  addr;
    logic [15:0] data;
    logic        retire;
  } ev_t;

  logic clk;
  logic rst;
  ev_t  q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   stall_cyc = -10;
  logic [5:0] exp_status = 6'b0;
  bit   mon_en = 1'b0;

  alu_writeback_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) bus ();

  alu_writeback #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected register-file activity of one accepted operation, from its architectural meaning.
  function automatic void push_op(input logic [31:0] res, input logic wide, input logic wen,
                                  input logic [2:0] rd, input int c);
    ev_t e;
    logic [2:0] hi_addr;
    hi_addr = rd + 3'd1;
    if (wide && wen) begin
      e = '{due: c + 1, we: 1'b1, addr: rd, data: res[15:0], retire: 1'b0};
      q.push_back(e);
      e = '{due: c + 2, we: 1'b1, addr: hi_addr, data: res[31:16], retire: 1'b1};
      q.push_back(e);
    end else begin
      e = '{due: c + 1, we: wen, addr: rd, data: res[15:0], retire: 1'b1};
      q.push_back(e);
    end
  endfunction

  // Monitor: compares every cycle's outputs with the scoreboard and the expected ready/status.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("in_ready", 32'(bus.in_ready), 32'(!rst && (cyc != stall_cyc)));
      chk("status", 32'(bus.status), 32'(exp_status));
      if (q.size() > 0 && q[0].due == cyc) begin
        chk("rf_we", 32'(bus.rf_we), 32'(q[0].we));
        chk("retire", 32'(bus.retire), 32'(q[0].retire));
        if (q[0].we) begin
          chk("rf_waddr", 32'(bus.rf_waddr), 32'(q[0].addr));
          chk("rf_wdata", 32'(bus.rf_wdata), 32'(q[0].data));
        end
        void'(q.pop_front());
      end else if (bus.rf_we || bus.retire) begin
        chk("unexpected_we_retire", 32'({bus.rf_we, bus.retire}), 32'(0));
      end else if (q.size() > 0 && q[0].due < cyc) begin
        chk("missing_write_cycle", 32'(cyc), 32'(q[0].due));
        void'(q.pop_front());
      end
    end
  end

  // Presents one operation each cycle until accepted (inputs held while stalled).
  task automatic issue(input logic [31:0] res, input logic wide, input logic wen,
                       input logic [2:0] rd, input logic [5:0] fl, input logic fwe,
                       output int waited);
    logic fired;
    fired  = 1'b0;
    waited = 0;
    for (int i = 0; i < 8 && !fired; i++) begin
      @(negedge clk);
      bus.in_valid   = 1'b1;
      bus.in_result  = res;
      bus.in_wide    = wide;
      bus.in_wen     = wen;
      bus.in_rd      = rd;
      bus.in_flags   = fl;
      bus.in_flag_we = fwe;
      fired = bus.in_ready;
      if (fired) begin
        push_op(res, wide, wen, rd, cyc);
        if (wide && wen) stall_cyc = cyc + 1;
      end else begin
        waited++;
      end
      @(posedge clk);
      #1;
      if (fired && fwe) exp_status = fl;
    end
    bus.in_valid = 1'b0;
    if (!fired) chk("accept_timeout", 32'(waited), 32'(0));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_result  = '0;
    bus.in_wide    = 1'b0;
    bus.in_wen     = 1'b0;
    bus.in_rd      = '0;
    bus.in_flags   = '0;
    bus.in_flag_we = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", 32'(bus.in_ready), 32'(0));
    chk("reset_rf_we", 32'(bus.rf_we), 32'(0));
    chk("reset_retire", 32'(bus.retire), 32'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("post_reset_in_ready", 32'(bus.in_ready), 32'(1));
    chk("post_reset_rf_waddr", 32'(bus.rf_waddr), 32'(0));
    chk("post_reset_rf_wdata", 32'(bus.rf_wdata), 32'(0));
    chk("post_reset_status", 32'(bus.status), 32'(0));

    // Narrow write, then idle.
    issue(32'h0000_1234, 1'b0, 1'b1, 3'd3, 6'b0, 1'b0, w);
    idle(2);

    // Wide write wrapping from register 7 to register 0.
    issue(32'hABCD_5678, 1'b1, 1'b1, 3'd7, 6'b0, 1'b0, w);
    idle(3);

    // Three narrow operations back to back.
    for (int i = 1; i <= 3; i++) begin
      issue(32'(i), 1'b0, 1'b1, 3'(i), 6'b0, 1'b0, w);
      chk("b2b_no_stall", 32'(w), 32'(0));
    end
    idle(2);

    // Flag-only operation with wide set but no write.
    issue(32'hFFFF_FFFF, 1'b1, 1'b0, 3'd5, 6'b010110, 1'b1, w);
    idle(2);
    chk("flag_only_status", 32'(bus.status), 32'(6'b010110));

    // Second wide operation held while the first occupies WR_LO.
    issue(32'h1111_2222, 1'b1, 1'b1, 3'd2, 6'b000001, 1'b1, w);
    issue(32'h3333_4444, 1'b1, 1'b1, 3'd4, 6'b100000, 1'b1, w);
    chk("stall_accept_wait", 32'(w), 32'(1));
    idle(3);

    // Reset during the high-half cycle drops that write and clears status.
    issue(32'h5555_6666, 1'b1, 1'b1, 3'd1, 6'b111111, 1'b1, w);
    @(posedge clk);
    #1;
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    chk("rst_drops_hi_we", 32'(bus.rf_we), 32'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_status = 6'b0;
    @(negedge clk);
    chk("after_rst_in_ready", 32'(bus.in_ready), 32'(1));
    chk("after_rst_status", 32'(bus.status), 32'(0));
    chk("after_rst_rf_we", 32'(bus.rf_we), 32'(0));

    // Randomized traffic against the scoreboard.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(3) == 0) idle(1);
      issue($urandom, 1'($urandom_range(1)), 1'($urandom_range(3) != 0),
            3'($urandom_range(7)), 6'($urandom_range(63)), 1'($urandom_range(1)), w);
    end
    idle(4);
    chk("scoreboard_drained", 32'(q.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
